alu_dispatch: RTL and testbench
===============================

# alu_dispatch

Execute-stage dispatch unit: the producer side of the ALU interface. It accepts one decoded-to-be RV32I instruction per cycle with its PC and register-file operands over a valid/ready handshake, and decodes it into the ALU control code and operand pair. It registers the result into a 2-entry skid pipeline and drives the ALU. It also consumes the ALU's `b_flag` to resolve conditional branches and computes the branch target.

## Interface
- `DATA_WIDTH`, 32, operand/PC width (only 32 supported).
- `clk`  in  1  clock; all state on rising edge.
- `rst_n`  in  1  reset, synchronous, active-low.
- `in_valid`  in  1  upstream offers an instruction.
- `in_ready`  out  1  dispatch can accept; transfer when `in_valid && in_ready`.
- `in_instr`  in  32  raw instruction.
- `in_pc`  in  DATA_WIDTH  instruction address.
- `in_rs1_val`, `in_rs2_val`  in  DATA_WIDTH  register operands.
- `out_valid`  out  1  dispatch entry presented to ALU/writeback.
- `out_ready`  in  1  downstream consumes; transfer when `out_valid && out_ready`.
- `alu_ctrl`  out  4  ALU opcode: ADD 0000, SUB 1000, SLL 0001, SLT 0010, SLTU 0011, XOR 0100, SRL 0101, SRA 1101, OR 0110, AND 0111.
- `alu_in_1`, `alu_in_2`  out  DATA_WIDTH  ALU operands.
- `b_flag`  in  1  ALU branch flag for the presented entry.
- `out_rd`  out  5  destination register.
- `out_we`  out  1  register write enable.
- `out_is_branch`  out  1  entry is a conditional branch.
- `out_target`  out  DATA_WIDTH  `pc + B-imm` (branches), else 0.
- `branch_taken`  out  1  `out_valid && out_is_branch && (b_flag ^ invert)`; combinational from `b_flag`.
- `out_illegal`  out  1  unsupported encoding.

## Operation
- Decode by opcode:
  - OP (0110011): `alu_ctrl={instr[30],funct3}`.
    - funct7 must be 0000000, or 0100000 only with funct3 000/101; otherwise illegal.
    - in_1=rs1, in_2=rs2, we=1.
  - OP-IMM (0010011): `alu_ctrl={0,funct3}`; for funct3=101, `alu_ctrl[3]=instr[30]`.
    - in_2 = sign-extended I-imm; for shifts (funct3 001/101), in_2 = zero-extended shamt `instr[24:20]`.
    - Shift funct7 other than 0000000, or 0100000 for 101, is illegal.
  - LUI: ADD, in_1=0, in_2=U-imm. AUIPC: ADD, in_1=pc, in_2=U-imm. Both we=1.
  - BRANCH: in_1=rs1, in_2=rs2, we=0, is_branch=1, target=pc+sign-extended B-imm (mod 2^32).
    - BEQ: SUB. BNE: SUB, invert. BLT: SLT. BGE: SLT, invert. BLTU: SLTU. BGEU: SLTU, invert.
    - funct3 010/011 is illegal.
- Illegal entries: alu_ctrl=ADD, operands 0, we=0, is_branch=0, illegal=1. They still flow through the pipeline in order.
- `out_rd=instr[11:7]` for OP/OP-IMM/LUI/AUIPC, else 0. `out_rd=0` forces we=0.
- Pipeline states:
  - EMPTY (out_valid=0): on accept, go to ONE.
  - ONE (main full): accept without drain loads the skid, go to TWO. Drain without accept goes to EMPTY. Simultaneous accept and drain replaces main, stays ONE.
  - TWO (main+skid full): in_ready=0. Drain moves skid to main, go to ONE.
- `in_ready` is registered: 1 unless state is TWO.

## Timing
- Reset values: out_valid=0, in_ready=1, all data outputs 0, alu_ctrl=0000, state EMPTY.
- Latency: accept in cycle N, presented with out_valid=1 in cycle N+1.
- Throughput: one instruction per cycle with out_ready held high.
- While `out_valid && !out_ready`, all `out_*`/`alu_*` are held stable. Order is strictly FIFO.
- `rst_n` low at any edge discards all entries, including a mid-stall entry. No handshake completes in that cycle.
- `branch_taken` is valid only in cycles where `out_valid=1`. Otherwise it is 0.

## Configuration
- `ALU_DISPATCH_SKID_EN` defined: 2-entry skid as above, `in_ready` registered.
- Undefined: single register stage, state TWO is absent, and `in_ready = !out_valid || out_ready` (combinational).
  - Latency is unchanged; full throughput is retained.
  - `in_ready` depends combinationally on `out_ready`.

## Test plan
- ADD x3,x1,x2 (0x002081B3), rs1=5, rs2=7, out_ready=1 → next cycle: alu_ctrl 0000, in_1 5, in_2 7, rd 3, we 1.
- SUB 0x402081B3 → alu_ctrl 1000. SRAI 0x4030D093 → alu_ctrl 1101, in_2=3, rd 1.
- BNE x1,x2,+8 (0x00209463), pc=0x100, b_flag=0 → alu_ctrl 1000, target 0x108, branch_taken=1, we=0. With b_flag=1 → branch_taken=0.
- out_ready=0 for 3 cycles while sending A, B, C back-to-back (skid build) → A held stable, B in skid, in_ready=0 and C not accepted. Release → A, B, C emerge on consecutive cycles.
- 0xFFFFFFFF → out_illegal=1, we=0, alu_ctrl 0000. LUI x5,0x12345 (0x123452B7) → in_1 0, in_2 0x12345000.
- rst_n=0 for one cycle in state TWO → next cycle out_valid=0, in_ready=1, outputs 0.

Source files
------------

// File: rtl/alu_dispatch.sv
// RV32I execute-stage dispatch: decodes one instruction per cycle into ALU control/operands.
// Define ALU_DISPATCH_SKID_EN for a 2-entry skid with registered in_ready; otherwise a single stage.
module alu_dispatch #(
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [31:0]           in_instr,
  input  logic [DATA_WIDTH-1:0] in_pc,
  input  logic [DATA_WIDTH-1:0] in_rs1_val,
  input  logic [DATA_WIDTH-1:0] in_rs2_val,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [3:0]            alu_ctrl,
  output logic [DATA_WIDTH-1:0] alu_in_1,
  output logic [DATA_WIDTH-1:0] alu_in_2,
  input  logic                  b_flag,
  output logic [4:0]            out_rd,
  output logic                  out_we,
  output logic                  out_is_branch,
  output logic [DATA_WIDTH-1:0] out_target,
  output logic                  branch_taken,
  output logic                  out_illegal
);

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  typedef struct packed {
    logic [3:0]            ctrl;
    logic [DATA_WIDTH-1:0] in1;
    logic [DATA_WIDTH-1:0] in2;
    logic [DATA_WIDTH-1:0] target;
    logic [4:0]            rd;
    logic                  we;
    logic                  is_branch;
    logic                  invert;
    logic                  illegal;
  } entry_t;

  logic [6:0]            opcode;
  logic [6:0]            funct7;
  logic [2:0]            funct3;
  logic [DATA_WIDTH-1:0] imm_i;
  logic [DATA_WIDTH-1:0] imm_u;
  logic [DATA_WIDTH-1:0] imm_b;
  logic [DATA_WIDTH-1:0] shamt;
  logic                  legal;
  entry_t                dec;
  entry_t                main_q;
  logic                  accept;
  logic                  drain;

  assign opcode = in_instr[6:0];
  assign funct3 = in_instr[14:12];
  assign funct7 = in_instr[31:25];
  assign imm_i  = {{(DATA_WIDTH-12){in_instr[31]}}, in_instr[31:20]};
  assign imm_u  = DATA_WIDTH'({in_instr[31:12], 12'b0});
  assign imm_b  = {{(DATA_WIDTH-13){in_instr[31]}}, in_instr[31], in_instr[7],
                   in_instr[30:25], in_instr[11:8], 1'b0};
  assign shamt  = {{(DATA_WIDTH-5){1'b0}}, in_instr[24:20]};

  always_comb begin
    dec   = '0;
    legal = 1'b1;
    case (opcode)
      OPC_OP: begin
        legal = (funct7 == 7'b0000000) ||
                (funct7 == 7'b0100000 && (funct3 == 3'b000 || funct3 == 3'b101));
        dec.ctrl = {in_instr[30], funct3};
        dec.in1  = in_rs1_val;
        dec.in2  = in_rs2_val;
        dec.rd   = in_instr[11:7];
        dec.we   = 1'b1;
      end
      OPC_OPIMM: begin
        dec.ctrl = {1'b0, funct3};
        dec.in1  = in_rs1_val;
        dec.in2  = imm_i;
        dec.rd   = in_instr[11:7];
        dec.we   = 1'b1;
        if (funct3 == 3'b001) begin
          legal   = (funct7 == 7'b0000000);
          dec.in2 = shamt;
        end else if (funct3 == 3'b101) begin
          legal       = (funct7 == 7'b0000000) || (funct7 == 7'b0100000);
          dec.ctrl[3] = in_instr[30];
          dec.in2     = shamt;
        end
      end
      OPC_LUI: begin
        dec.in2 = imm_u;
        dec.rd  = in_instr[11:7];
        dec.we  = 1'b1;
      end
      OPC_AUIPC: begin
        dec.in1 = in_pc;
        dec.in2 = imm_u;
        dec.rd  = in_instr[11:7];
        dec.we  = 1'b1;
      end
      OPC_BRANCH: begin
        dec.in1       = in_rs1_val;
        dec.in2       = in_rs2_val;
        dec.is_branch = 1'b1;
        dec.target    = in_pc + imm_b;
        // Odd funct3 (BNE/BGE/BGEU) is the complement of its even partner's flag
        dec.invert    = funct3[0];
        case (funct3[2:1])
          2'b00:   dec.ctrl = 4'b1000;
          2'b10:   dec.ctrl = 4'b0010;
          2'b11:   dec.ctrl = 4'b0011;
          default: legal = 1'b0;
        endcase
      end
      default: legal = 1'b0;
    endcase
    if (!legal) begin
      dec         = '0;
      dec.illegal = 1'b1;
    end
    if (dec.rd == 5'd0) dec.we = 1'b0;
  end

  assign accept = in_valid && in_ready;
  assign drain  = out_valid && out_ready;

`ifdef ALU_DISPATCH_SKID_EN
  typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;
  state_t state;
  entry_t skid_q;
  logic   ready_q;

  assign in_ready = ready_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= EMPTY;
      main_q  <= '0;
      skid_q  <= '0;
      ready_q <= 1'b1;
    end else begin
      case (state)
        EMPTY: begin
          if (accept) begin
            main_q <= dec;
            state  <= ONE;
          end
        end
        ONE: begin
          if (accept && !drain) begin
            skid_q  <= dec;
            state   <= TWO;
            ready_q <= 1'b0;
          end else if (!accept && drain) begin
            state <= EMPTY;
          end else if (accept && drain) begin
            main_q <= dec;
          end
        end
        TWO: begin
          if (drain) begin
            main_q  <= skid_q;
            state   <= ONE;
            ready_q <= 1'b1;
          end
        end
        default: begin
          state   <= EMPTY;
          ready_q <= 1'b1;
        end
      endcase
    end
  end
`else
  typedef enum logic {EMPTY, ONE} state_t;
  state_t state;

  assign in_ready = !out_valid || out_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= EMPTY;
      main_q <= '0;
    end else if (accept) begin
      main_q <= dec;
      state  <= ONE;
    end else if (drain) begin
      state <= EMPTY;
    end
  end
`endif

  assign out_valid     = (state != EMPTY);
  assign alu_ctrl      = main_q.ctrl;
  assign alu_in_1      = main_q.in1;
  assign alu_in_2      = main_q.in2;
  assign out_rd        = main_q.rd;
  assign out_we        = main_q.we;
  assign out_is_branch = main_q.is_branch;
  assign out_target    = main_q.target;
  assign out_illegal   = main_q.illegal;
  assign branch_taken  = out_valid && main_q.is_branch && (b_flag ^ main_q.invert);

endmodule

// File: tb/tb_alu_dispatch.sv
// Self-checking bench for alu_dispatch: directed vector table, stall/reset sequences, randomized traffic.
module tb_alu_dispatch;
`ifdef ALU_DISPATCH_SKID_EN
  localparam bit SKID = 1'b1;
  localparam int CAP  = 2;
`else
  localparam bit SKID = 1'b0;
  localparam int CAP  = 1;
`endif

  logic        clk = 1'b0;
  logic        rst_n, in_valid, in_ready, out_valid, out_ready, b_flag;
  logic        out_we, out_is_branch, branch_taken, out_illegal;
  logic [31:0] in_instr, in_pc, in_rs1_val, in_rs2_val, alu_in_1, alu_in_2, out_target;
  logic [3:0]  alu_ctrl;
  logic [4:0]  out_rd;
  int          n_checks = 0;
  int          n_fail = 0;

  always #5 clk = ~clk;

  alu_dispatch #(.DATA_WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_instr(in_instr), .in_pc(in_pc), .in_rs1_val(in_rs1_val), .in_rs2_val(in_rs2_val),
    .out_valid(out_valid), .out_ready(out_ready), .alu_ctrl(alu_ctrl),
    .alu_in_1(alu_in_1), .alu_in_2(alu_in_2), .b_flag(b_flag), .out_rd(out_rd),
    .out_we(out_we), .out_is_branch(out_is_branch), .out_target(out_target),
    .branch_taken(branch_taken), .out_illegal(out_illegal)
  );

  typedef struct {
    logic [3:0]  ctrl;
    logic [31:0] in1, in2, target;
    logic [4:0]  rd;
    logic        we, br, inv, ill;
  } exp_t;

  typedef struct {
    logic [31:0] instr, pc, rs1, rs2;
  } stim_t;

  typedef struct {
    logic [31:0] instr, pc, rs1, rs2;
    logic        bf;
    logic [3:0]  ctrl;
    logic [31:0] in1, in2;
    logic [4:0]  rd;
    logic        we, br;
    logic [31:0] target;
    logic        taken, ill;
  } vec_t;

  exp_t  q[$];
  stim_t pend[$];
  vec_t  vt[15];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic string f3_name(input int f3);
    case (f3)
      0: return "ADD";
      1: return "SLL";
      2: return "SLT";
      3: return "SLTU";
      4: return "XOR";
      5: return "SRL";
      6: return "OR";
      default: return "AND";
    endcase
  endfunction

  function automatic logic [3:0] alu_code(input string mn);
    if (mn == "SUB")  return 4'b1000;
    if (mn == "SLL")  return 4'b0001;
    if (mn == "SLT")  return 4'b0010;
    if (mn == "SLTU") return 4'b0011;
    if (mn == "XOR")  return 4'b0100;
    if (mn == "SRL")  return 4'b0101;
    if (mn == "SRA")  return 4'b1101;
    if (mn == "OR")   return 4'b0110;
    if (mn == "AND")  return 4'b0111;
    return 4'b0000;
  endfunction

  // Reference decode: name the operation, then look up its ALU code.
  function automatic exp_t ref_decode(input logic [31:0] ins, input logic [31:0] pc,
                                      input logic [31:0] rs1, input logic [31:0] rs2);
    exp_t  e;
    string mn;
    bit    ok;
    int    op, f3, f7, simm, boff;
    e    = '{default: '0};
    mn   = "ADD";
    ok   = 1'b1;
    op   = int'(ins[6:0]);
    f3   = int'(ins[14:12]);
    f7   = int'(ins[31:25]);
    simm = $signed(ins[31:20]);
    boff = $signed({ins[31], ins[7], ins[30:25], ins[11:8], 1'b0});
    if (op == 'h33) begin
      if (f7 == 0) mn = f3_name(f3);
      else if (f7 == 'h20 && f3 == 0) mn = "SUB";
      else if (f7 == 'h20 && f3 == 5) mn = "SRA";
      else ok = 1'b0;
      e.in1 = rs1; e.in2 = rs2; e.rd = ins[11:7]; e.we = 1'b1;
    end else if (op == 'h13) begin
      e.in1 = rs1; e.rd = ins[11:7]; e.we = 1'b1;
      if (f3 != 1 && f3 != 5) begin
        mn = f3_name(f3); e.in2 = 32'(simm);
      end else if (f7 == 0) begin
        mn = f3_name(f3); e.in2 = 32'(ins[24:20]);
      end else if (f7 == 'h20 && f3 == 5) begin
        mn = "SRA"; e.in2 = 32'(ins[24:20]);
      end else ok = 1'b0;
    end else if (op == 'h37) begin
      e.in2 = {ins[31:12], 12'h000}; e.rd = ins[11:7]; e.we = 1'b1;
    end else if (op == 'h17) begin
      e.in1 = pc; e.in2 = {ins[31:12], 12'h000}; e.rd = ins[11:7]; e.we = 1'b1;
    end else if (op == 'h63) begin
      case (f3)
        0: mn = "SUB";
        1: begin mn = "SUB"; e.inv = 1'b1; end
        4: mn = "SLT";
        5: begin mn = "SLT"; e.inv = 1'b1; end
        6: mn = "SLTU";
        7: begin mn = "SLTU"; e.inv = 1'b1; end
        default: ok = 1'b0;
      endcase
      e.in1 = rs1; e.in2 = rs2; e.br = 1'b1; e.target = pc + 32'(boff);
    end else ok = 1'b0;
    e.ctrl = alu_code(mn);
    if (!ok) begin
      e = '{default: '0};
      e.ill = 1'b1;
    end
    if (e.rd == 5'd0) e.we = 1'b0;
    return e;
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [31:0] r;
    int          k;
    r = $urandom;
    k = $urandom_range(0, 11);
    case (k)
      0, 1, 10: r[6:0] = 7'h33;
      2, 3, 11: r[6:0] = 7'h13;
      4:        r[6:0] = 7'h37;
      5:        r[6:0] = 7'h17;
      6, 7, 8:  r[6:0] = 7'h63;
      default:  ;
    endcase
    if (k <= 3 || k >= 10) begin
      case ($urandom_range(0, 3))
        0, 1:    r[31:25] = 7'h00;
        2:       r[31:25] = 7'h20;
        default: ;
      endcase
    end
    return r;
  endfunction

  // One clock of traffic checked against the queue model.
  task automatic cycle(input logic v, input logic [31:0] ins, input logic [31:0] pc,
                       input logic [31:0] r1, input logic [31:0] r2,
                       input logic ordy, input logic bf, output bit acc);
    exp_t e;
    bit   exp_rdy, drn;
    in_valid = v; in_instr = ins; in_pc = pc; in_rs1_val = r1; in_rs2_val = r2;
    out_ready = ordy; b_flag = bf;
    #1;
    exp_rdy = (q.size() < CAP) || (!SKID && ordy);
    chk("in_ready", 32'(in_ready), 32'(exp_rdy));
    chk("out_valid", 32'(out_valid), 32'(q.size() > 0));
    if (q.size() > 0) begin
      e = q[0];
      chk("alu_ctrl", 32'(alu_ctrl), 32'(e.ctrl));
      chk("alu_in_1", alu_in_1, e.in1);
      chk("alu_in_2", alu_in_2, e.in2);
      chk("out_rd", 32'(out_rd), 32'(e.rd));
      chk("out_we", 32'(out_we), 32'(e.we));
      chk("out_is_branch", 32'(out_is_branch), 32'(e.br));
      chk("out_target", out_target, e.target);
      chk("out_illegal", 32'(out_illegal), 32'(e.ill));
      chk("branch_taken", 32'(branch_taken), 32'(e.br && (bf ^ e.inv)));
    end else begin
      chk("branch_taken idle", 32'(branch_taken), 32'd0);
    end
    acc = v && exp_rdy;
    drn = (q.size() > 0) && ordy;
    @(posedge clk);
    if (drn) void'(q.pop_front());
    if (acc) q.push_back(ref_decode(ins, pc, r1, r2));
    #1;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, " out_valid"}, 32'(out_valid), 32'd0);
    chk({tag, " in_ready"}, 32'(in_ready), 32'd1);
    chk({tag, " alu_ctrl"}, 32'(alu_ctrl), 32'd0);
    chk({tag, " alu_in_1"}, alu_in_1, 32'd0);
    chk({tag, " alu_in_2"}, alu_in_2, 32'd0);
    chk({tag, " out_rd"}, 32'(out_rd), 32'd0);
    chk({tag, " out_we"}, 32'(out_we), 32'd0);
    chk({tag, " out_is_branch"}, 32'(out_is_branch), 32'd0);
    chk({tag, " out_target"}, out_target, 32'd0);
    chk({tag, " out_illegal"}, 32'(out_illegal), 32'd0);
    chk({tag, " branch_taken"}, 32'(branch_taken), 32'd0);
  endtask

  // A handshake is offered during the reset cycle; it must not complete.
  task automatic do_reset(input string tag);
    rst_n = 1'b0; in_valid = 1'b1; in_instr = 32'h002081B3; in_pc = 32'h0;
    in_rs1_val = 32'd1; in_rs2_val = 32'd2; out_ready = 1'b1; b_flag = 1'b1;
    @(posedge clk);
    q.delete();
    #1;
    rst_n = 1'b1; in_valid = 1'b0;
    #1;
    chk_zero(tag);
  endtask

  initial begin
    bit    acc;
    stim_t s;
    int    guard;

    vt[0]  = '{32'h002081B3, 32'h0, 32'd5, 32'd7, 1'b0, 4'h0, 32'd5, 32'd7, 5'd3, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0};
    vt[1]  = '{32'h402081B3, 32'h0, 32'd9, 32'd4, 1'b0, 4'h8, 32'd9, 32'd4, 5'd3, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0};
    vt[2]  = '{32'h4030D093, 32'h0, 32'h80000000, 32'h1234, 1'b0, 4'hD, 32'h80000000, 32'd3, 5'd1, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0};
    vt[3]  = '{32'h00209463, 32'h100, 32'd1, 32'd2, 1'b0, 4'h8, 32'd1, 32'd2, 5'd0, 1'b0, 1'b1, 32'h108, 1'b1, 1'b0};
    vt[4]  = '{32'h00209463, 32'h100, 32'd1, 32'd2, 1'b1, 4'h8, 32'd1, 32'd2, 5'd0, 1'b0, 1'b1, 32'h108, 1'b0, 1'b0};
    vt[5]  = '{32'hFFFFFFFF, 32'h200, 32'd11, 32'd22, 1'b1, 4'h0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1};
    vt[6]  = '{32'h123452B7, 32'h40, 32'h55, 32'h66, 1'b0, 4'h0, 32'h0, 32'h12345000, 5'd5, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0};
    vt[7]  = '{32'h12345297, 32'h40, 32'h55, 32'h66, 1'b0, 4'h0, 32'h40, 32'h12345000, 5'd5, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0};
    vt[8]  = '{32'hFFF08013, 32'h0, 32'd10, 32'd3, 1'b0, 4'h0, 32'd10, 32'hFFFFFFFF, 5'd0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0};
    vt[9]  = '{32'hFE20FEE3, 32'h0, 32'd3, 32'd9, 1'b0, 4'h3, 32'd3, 32'd9, 5'd0, 1'b0, 1'b1, 32'hFFFFFFFC, 1'b1, 1'b0};
    vt[10] = '{32'h022081B3, 32'h0, 32'd3, 32'd9, 1'b0, 4'h0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1};
    vt[11] = '{32'h40109093, 32'h0, 32'd3, 32'd9, 1'b0, 4'h0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1};
    vt[12] = '{32'h0020A463, 32'h0, 32'd3, 32'd9, 1'b1, 4'h0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1};
    vt[13] = '{32'h8000E213, 32'h0, 32'h0F0F0000, 32'd9, 1'b0, 4'h6, 32'h0F0F0000, 32'hFFFFF800, 5'd4, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0};
    vt[14] = '{32'h0020B3B3, 32'h0, 32'd6, 32'd8, 1'b0, 4'h3, 32'd6, 32'd8, 5'd7, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0};

    rst_n = 1'b0; in_valid = 1'b0; in_instr = '0; in_pc = '0; in_rs1_val = '0; in_rs2_val = '0;
    out_ready = 1'b0; b_flag = 1'b0;
    repeat (2) @(posedge clk);
    do_reset("reset");

    // Directed vectors, one per cycle with out_ready high.
    for (int i = 0; i < 15; i++) begin
      in_valid = 1'b1; in_instr = vt[i].instr; in_pc = vt[i].pc;
      in_rs1_val = vt[i].rs1; in_rs2_val = vt[i].rs2; out_ready = 1'b1; b_flag = vt[i].bf;
      #1;
      chk($sformatf("v%0d in_ready", i), 32'(in_ready), 32'd1);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      chk($sformatf("v%0d out_valid", i), 32'(out_valid), 32'd1);
      chk($sformatf("v%0d alu_ctrl", i), 32'(alu_ctrl), 32'(vt[i].ctrl));
      chk($sformatf("v%0d alu_in_1", i), alu_in_1, vt[i].in1);
      chk($sformatf("v%0d alu_in_2", i), alu_in_2, vt[i].in2);
      chk($sformatf("v%0d out_rd", i), 32'(out_rd), 32'(vt[i].rd));
      chk($sformatf("v%0d out_we", i), 32'(out_we), 32'(vt[i].we));
      chk($sformatf("v%0d out_is_branch", i), 32'(out_is_branch), 32'(vt[i].br));
      chk($sformatf("v%0d out_target", i), out_target, vt[i].target);
      chk($sformatf("v%0d branch_taken", i), 32'(branch_taken), 32'(vt[i].taken));
      chk($sformatf("v%0d out_illegal", i), 32'(out_illegal), 32'(vt[i].ill));
    end
    @(posedge clk);
    #1;
    chk("drained out_valid", 32'(out_valid), 32'd0);

    // Back-to-back A, B, C while the consumer stalls for three cycles.
    for (int i = 0; i < 3; i++) begin
      s.instr = 32'h002081B3; s.pc = 32'h300 + 32'(4 * i);
      s.rs1 = 32'hA + 32'(i); s.rs2 = 32'h100 + 32'(i);
      pend.push_back(s);
    end
    for (int c = 0; c < 3; c++) begin
      s = pend[0];
      cycle(1'b1, s.instr, s.pc, s.rs1, s.rs2, 1'b0, 1'b0, acc);
      if (acc) void'(pend.pop_front());
    end
    #1;
    chk("stall in_ready", 32'(in_ready), 32'd0);
    chk("stall out_valid", 32'(out_valid), 32'd1);
    chk("stall A held", alu_in_1, 32'hA);
    guard = 0;
    while ((pend.size() > 0 || q.size() > 0) && guard < 20) begin
      if (pend.size() > 0) begin
        s = pend[0];
        cycle(1'b1, s.instr, s.pc, s.rs1, s.rs2, 1'b1, 1'b0, acc);
        if (acc) void'(pend.pop_front());
      end else begin
        cycle(1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b1, 1'b0, acc);
      end
      guard++;
    end
    chk("release drained", 32'(pend.size() + q.size()), 32'd0);

    // Fill, then reset mid-stall.
    for (int c = 0; c < 2; c++)
      cycle(1'b1, 32'h402081B3, 32'h0, 32'd50 + 32'(c), 32'd1, 1'b0, 1'b0, acc);
    do_reset("stall reset");

    for (int n = 0; n < 800; n++) begin
      if ($urandom_range(0, 99) == 0) begin
        do_reset("rand reset");
      end else begin
        cycle(1'($urandom_range(0, 9) < 7), rand_instr(), $urandom, $urandom, $urandom,
              1'($urandom_range(0, 9) < 6), 1'($urandom_range(0, 1)), acc);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
